// File: rtl/jump_target_unit.sv
// jump_target_unit: computes jump/branch/register/return targets with a return-address stack
module jump_target_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int REGION_BITS = 4,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        mode,
  input  logic                              link,
  input  logic [ADDR_WIDTH-REGION_BITS-3:0] raw_address,
  input  logic [15:0]                       branch_offset,
  input  logic [ADDR_WIDTH-1:0]             reg_address,
  input  logic [ADDR_WIDTH-1:0]             pc_plus_four,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ADDR_WIDTH-1:0]             target,
  output logic                              misaligned,
  output logic                              ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);
  localparam logic [1:0] M_JUMP = 2'd0, M_BRANCH = 2'd1, M_RETURN = 2'd3;
  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]         top, wr_idx;
  logic [PW:0]           count;
  logic                  accept, empty, pop, push, underflow;
  logic [ADDR_WIDTH-1:0] offset_ext, next_target;
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready && !flush;
  assign empty      = count == '0;
  assign underflow  = mode == M_RETURN && empty;
  assign pop        = accept && mode == M_RETURN && !empty;
  assign push       = accept && link;
  // A pop followed by a push in the same request lands on the slot just vacated.
  assign wr_idx     = pop ? top : top + 1'b1;
  assign offset_ext = {{(ADDR_WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
  // Target selection for the four request modes.
  always_comb begin
    next_target = mode == M_JUMP   ? {pc_plus_four[ADDR_WIDTH-1 -: REGION_BITS], raw_address, 2'b00} :
                  mode == M_BRANCH ? pc_plus_four + offset_ext :
                  pop              ? ras[top] : reg_address;
  end
  // Stack pointer and occupancy; a full push wraps over the oldest entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      top   <= '0;
    end else if (pop && !push) begin
      count <= count - 1'b1;
      top   <= top - 1'b1;
    end else if (push && !pop) begin
      count <= count == FULL ? count : count + 1'b1;
      top   <= top + 1'b1;
    end
  end
  // Stack storage; entries beyond count are never read so they need no reset.
  always_ff @(posedge clock) begin
    if (push) ras[wr_idx] <= pc_plus_four + ADDR_WIDTH'(4);
  end
  // Registered result with valid/ready hold and flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      target        <= '0;
      misaligned    <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      target        <= next_target;
      misaligned    <= |next_target[1:0];
      ras_underflow <= underflow;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_jump_target_unit.sv
// tb_jump_target_unit: scoreboard bench for jump_target_unit
module tb_jump_target_unit;
  logic        clock = 0, reset = 1, in_valid = 0, link = 0, flush = 0, out_ready = 1;
  logic [1:0]  mode = 0;
  logic [25:0] raw_address = 0;
  logic [15:0] branch_offset = 0;
  logic [31:0] reg_address = 0, pc_plus_four = 0;
  logic        in_ready, out_valid, misaligned, ras_underflow;
  logic [31:0] target;
  typedef struct packed {logic [31:0] t; logic mis; logic unf;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] ras_m[$];
  logic [31:0] dummy;
  int          checks = 0, failures = 0;

  jump_target_unit dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .link(link), .raw_address(raw_address), .branch_offset(branch_offset),
    .reg_address(reg_address), .pc_plus_four(pc_plus_four), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .target(target),
    .misaligned(misaligned), .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic model(input logic [1:0] m, input logic lk, input logic [25:0] raw,
                       input logic [15:0] off, input logic [31:0] ra, input logic [31:0] pc);
    exp_t e;
    e.unf = 0;
    case (m)
      2'd0: e.t = {pc[31:28], raw, 2'b00};
      2'd1: e.t = pc + ({{16{off[15]}}, off} << 2);
      2'd2: e.t = ra;
      default: if (ras_m.size() > 0) e.t = ras_m.pop_back(); else begin e.t = ra; e.unf = 1; end
    endcase
    e.mis = e.t[1:0] != 2'b00;
    if (lk) begin
      ras_m.push_back(pc + 32'd4);
      if (ras_m.size() > 4) dummy = ras_m.pop_front();
    end
    exp_q.push_back(e);
  endtask

  task automatic set_req(input logic [1:0] m, input logic lk, input logic [25:0] raw,
                         input logic [15:0] off, input logic [31:0] ra, input logic [31:0] pc);
    mode = m; link = lk; raw_address = raw; branch_offset = off; reg_address = ra; pc_plus_four = pc;
  endtask

  task automatic issue(input logic [1:0] m, input logic lk, input logic [25:0] raw,
                       input logic [15:0] off, input logic [31:0] ra, input logic [31:0] pc);
    @(negedge clock);
    set_req(m, lk, raw, off, ra, pc);
    in_valid = 1;
    model(m, lk, raw, off, ra, pc);
    @(posedge clock); #1;
    in_valid = 0;
    link = 0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, target, misaligned, ras_underflow, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset: got v=%b t=%h m=%b u=%b r=%b want v=0 t=0 m=0 u=0 r=1",
               out_valid, target, misaligned, ras_underflow, in_ready);
    end
    @(negedge clock) reset = 0;
  endtask

  task automatic test_jump;
    exp_t e;
    logic [25:0] raws [2] = '{26'h0000123, 26'h3FFFFFF};
    logic [31:0] pcs  [2] = '{32'h40001000, 32'hA0000000};
    for (int i = 0; i < 2; i++) begin
      issue(2'd0, 0, raws[i], 16'h0, 32'h0, pcs[i]);
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, e.t, e.mis, e.unf}) begin
        failures++;
        $display("FAIL jump%0d: got v=%b t=%h m=%b u=%b want v=1 t=%h m=%b u=%b",
                 i, out_valid, target, misaligned, ras_underflow, e.t, e.mis, e.unf);
      end
    end
  endtask

  task automatic test_branch;
    exp_t e;
    logic [15:0] offs [2] = '{16'hFFFC, 16'h0008};
    logic [31:0] pcs  [2] = '{32'h00000010, 32'hFFFFFFF0};
    for (int i = 0; i < 2; i++) begin
      issue(2'd1, 0, 26'h0, offs[i], 32'h0, pcs[i]);
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, e.t, e.mis, e.unf}) begin
        failures++;
        $display("FAIL branch%0d: got v=%b t=%h m=%b u=%b want v=1 t=%h m=%b u=%b",
                 i, out_valid, target, misaligned, ras_underflow, e.t, e.mis, e.unf);
      end
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_ras;
    exp_t e;
    for (int i = 1; i <= 5; i++) begin
      issue(2'd0, 1, 26'h0, 16'h0, 32'h0, 32'(i) << 8);
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, e.t, e.mis, e.unf}) begin
        failures++;
        $display("FAIL ras_push%0d: got v=%b t=%h m=%b u=%b want v=1 t=%h m=%b u=%b",
                 i, out_valid, target, misaligned, ras_underflow, e.t, e.mis, e.unf);
      end
    end
    for (int i = 1; i <= 5; i++) begin
      issue(2'd3, 0, 26'h0, 16'h0, 32'h0000ABC3, 32'h0);
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, e.t, e.mis, e.unf}) begin
        failures++;
        $display("FAIL ras_pop%0d: got v=%b t=%h m=%b u=%b want v=1 t=%h m=%b u=%b",
                 i, out_valid, target, misaligned, ras_underflow, e.t, e.mis, e.unf);
      end
    end
  endtask

  task automatic test_return_link;
    exp_t e;
    logic        lks [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ras [4] = '{32'h20, 32'h30, 32'h40, 32'h48};
    logic [31:0] pcs [4] = '{32'h100, 32'h300, 32'h500, 32'h700};
    for (int i = 0; i < 4; i++) begin
      issue(2'd3, lks[i], 26'h0, 16'h0, ras[i], pcs[i]);
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, e.t, e.mis, e.unf}) begin
        failures++;
        $display("FAIL ret_link%0d: got v=%b t=%h m=%b u=%b want v=1 t=%h m=%b u=%b",
                 i, out_valid, target, misaligned, ras_underflow, e.t, e.mis, e.unf);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t a, b;
    @(posedge clock); #1;
    @(negedge clock);
    out_ready = 0;
    set_req(2'd2, 0, 26'h0, 16'h0, 32'h1000, 32'h0);
    in_valid = 1;
    model(2'd2, 0, 26'h0, 16'h0, 32'h1000, 32'h0);
    @(posedge clock); #1;
    a = exp_q.pop_front();
    checks++;
    if ({out_valid, target} !== {1'b1, a.t}) begin
      failures++;
      $display("FAIL hold_first: got v=%b t=%h want v=1 t=%h", out_valid, target, a.t);
    end
    set_req(2'd2, 0, 26'h0, 16'h0, 32'h2000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_ready%0d: got in_ready=%b want 0", i, in_ready);
      end
      @(posedge clock); #1;
      checks++;
      if ({out_valid, target} !== {1'b1, a.t}) begin
        failures++;
        $display("FAIL hold_stable%0d: got v=%b t=%h want v=1 t=%h", i, out_valid, target, a.t);
      end
    end
    @(negedge clock);
    out_ready = 1;
    model(2'd2, 0, 26'h0, 16'h0, 32'h2000, 32'h0);
    @(posedge clock); #1;
    in_valid = 0;
    b = exp_q.pop_front();
    checks++;
    if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, b.t, b.mis, b.unf}) begin
      failures++;
      $display("FAIL no_bubble: got v=%b t=%h want v=1 t=%h", out_valid, target, b.t);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reg_flush;
    exp_t e;
    issue(2'd2, 0, 26'h0, 16'h0, 32'h00000102, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, e.t, e.mis, e.unf}) begin
      failures++;
      $display("FAIL reg_mis: got v=%b t=%h m=%b u=%b want v=1 t=%h m=%b u=%b",
               out_valid, target, misaligned, ras_underflow, e.t, e.mis, e.unf);
    end
    issue(2'd0, 1, 26'h0, 16'h0, 32'h0, 32'h700);
    e = exp_q.pop_front();
    checks++;
    if ({out_valid, target} !== {1'b1, e.t}) begin
      failures++;
      $display("FAIL flush_push: got v=%b t=%h want v=1 t=%h", out_valid, target, e.t);
    end
    @(posedge clock); #1;
    out_ready = 0;
    issue(2'd2, 0, 26'h0, 16'h0, 32'h200, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({out_valid, target} !== {1'b1, e.t}) begin
      failures++;
      $display("FAIL flush_pending: got v=%b t=%h want v=1 t=%h", out_valid, target, e.t);
    end
    @(negedge clock);
    flush = 1;
    set_req(2'd0, 1, 26'h0, 16'h0, 32'h0, 32'h900);
    in_valid = 1;
    @(posedge clock); #1;
    flush = 0; in_valid = 0; link = 0; out_ready = 1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: got out_valid=%b want 0", out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      issue(2'd3, 0, 26'h0, 16'h0, 32'h55, 32'h0);
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, e.t, e.mis, e.unf}) begin
        failures++;
        $display("FAIL flush_ras%0d: got v=%b t=%h m=%b u=%b want v=1 t=%h m=%b u=%b",
                 i, out_valid, target, misaligned, ras_underflow, e.t, e.mis, e.unf);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    issue(2'd0, 1, 26'h0, 16'h0, 32'h0, 32'h100);
    e = exp_q.pop_front();
    @(posedge clock); #1;
    out_ready = 0;
    issue(2'd0, 1, 26'h0, 16'h0, 32'h0, 32'h200);
    e = exp_q.pop_front();
    checks++;
    if ({out_valid, target} !== {1'b1, e.t}) begin
      failures++;
      $display("FAIL rst_pending: got v=%b t=%h want v=1 t=%h", out_valid, target, e.t);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({out_valid, target, misaligned, ras_underflow} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_async: got v=%b t=%h m=%b u=%b want v=0 t=0 m=0 u=0",
               out_valid, target, misaligned, ras_underflow);
    end
    ras_m.delete();
    exp_q.delete();
    @(negedge clock);
    reset = 0;
    out_ready = 1;
    issue(2'd3, 0, 26'h0, 16'h0, 32'h3000, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({out_valid, target, misaligned, ras_underflow} !== {1'b1, e.t, e.mis, e.unf}) begin
      failures++;
      $display("FAIL rst_return: got v=%b t=%h m=%b u=%b want v=1 t=%h m=%b u=%b",
               out_valid, target, misaligned, ras_underflow, e.t, e.mis, e.unf);
    end
  endtask

  initial begin
    test_reset;
    test_jump;
    test_branch;
    test_ras;
    test_return_link;
    test_back_to_back;
    test_reg_flush;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
